// File: rtl/seven_seg_capture.sv
// seven_seg_capture: passive receiver for a multiplexed, active-low 7-segment
// display bus. It rebuilds the four digits as raw patterns and hex nibbles, and
// pulses FRAME_DONE once every digit has been captured.
// Optional feature macro: SEG_TIMEOUT_EN. When it is defined, STALE flags a missing
// frame after TIMEOUT_CYCLES. When it is undefined, STALE is tied low.
module seven_seg_capture #(
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 400000,
   parameter int CNT_WIDTH      = 19
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_seg_select,
   input  logic [7:0] i_dec_out,
   output logic [7:0] o_seg0,
   output logic [7:0] o_seg1,
   output logic [7:0] o_seg2,
   output logic [7:0] o_seg3,
   output logic [3:0] o_hex0,
   output logic [3:0] o_hex1,
   output logic [3:0] o_hex2,
   output logic [3:0] o_hex3,
   output logic [3:0] o_hex_ok,
   output logic       o_frame_done,
   output logic       o_stale
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LP_SETTLE_MAX = CNT_WIDTH'(SETTLE_CYCLES - 1);

   // Elaboration guard: the counters must be wide enough to hold the timeout value
   if ((TIMEOUT_CYCLES >> CNT_WIDTH) != 0) begin : g_cnt_width_too_small
      $error("CNT_WIDTH cannot hold TIMEOUT_CYCLES");
   end

   // Glyph decode. The input is the active-low {g..a}, so invert it before matching.
   // The result is {match, nibble}, and a non-glyph yields all zeros.
   function automatic logic [4:0] f_decode(input logic [6:0] pat_n);
      logic [6:0] lit;
      lit = ~pat_n;
      case (lit)
         7'h3F:   f_decode = {1'b1, 4'h0};
         7'h06:   f_decode = {1'b1, 4'h1};
         7'h5B:   f_decode = {1'b1, 4'h2};
         7'h4F:   f_decode = {1'b1, 4'h3};
         7'h66:   f_decode = {1'b1, 4'h4};
         7'h6D:   f_decode = {1'b1, 4'h5};
         7'h7D:   f_decode = {1'b1, 4'h6};
         7'h07:   f_decode = {1'b1, 4'h7};
         7'h7F:   f_decode = {1'b1, 4'h8};
         7'h6F:   f_decode = {1'b1, 4'h9};
         7'h77:   f_decode = {1'b1, 4'hA};
         7'h7C:   f_decode = {1'b1, 4'hB};
         7'h39:   f_decode = {1'b1, 4'hC};
         7'h5E:   f_decode = {1'b1, 4'hD};
         7'h79:   f_decode = {1'b1, 4'hE};
         7'h71:   f_decode = {1'b1, 4'hF};
         default: f_decode = 5'b0_0000;
      endcase
   endfunction

   logic [3:0]           r_sel_s1, r_sel_s2, r_sel_prev;
   logic [7:0]           r_dec_s1, r_dec_s2, r_dec_prev;
   state_t               r_state, w_state_next;
   logic [CNT_WIDTH-1:0] r_settle_cnt;
   logic [7:0]           r_seg [4];
   logic [3:0]           r_hex [4];
   logic [3:0]           r_hex_ok;
   logic [3:0]           r_seen;
   logic                 r_frame_done;
   logic                 w_sel_valid;
   logic [1:0]           w_sel_idx;
   logic                 w_stable;
   logic                 w_capture;
   logic [4:0]           w_dec;

   // Two-flop synchroniser plus a one-cycle history for change detection.
   // The flops idle high, which is the blanked and undriven bus level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sel_s1   <= 4'hF;
         r_sel_s2   <= 4'hF;
         r_sel_prev <= 4'hF;
         r_dec_s1   <= 8'hFF;
         r_dec_s2   <= 8'hFF;
         r_dec_prev <= 8'hFF;
      end else begin
         r_sel_s1   <= i_seg_select;
         r_sel_s2   <= r_sel_s1;
         r_sel_prev <= r_sel_s2;
         r_dec_s1   <= i_dec_out;
         r_dec_s2   <= r_dec_s1;
         r_dec_prev <= r_dec_s2;
      end
   end

   // Select qualification: a valid select has exactly one anode low. Also flag stable inputs.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_idx   = 2'd0;
      case (r_sel_s2)
         4'b1110: begin w_sel_valid = 1'b1; w_sel_idx = 2'd0; end
         4'b1101: begin w_sel_valid = 1'b1; w_sel_idx = 2'd1; end
         4'b1011: begin w_sel_valid = 1'b1; w_sel_idx = 2'd2; end
         4'b0111: begin w_sel_valid = 1'b1; w_sel_idx = 2'd3; end
         default: begin w_sel_valid = 1'b0; w_sel_idx = 2'd0; end
      endcase
      w_stable  = (r_sel_s2 == r_sel_prev) && (r_dec_s2 == r_dec_prev);
      w_capture = (r_state == ST_CAPTURE) && w_sel_valid;
      w_dec     = f_decode(r_dec_s2[6:0]);
   end

   // Next-state logic. HOLD guarantees at most one capture per dwell.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_valid) w_state_next = ST_SETTLE;
            else             w_state_next = ST_IDLE;
         end
         ST_SETTLE: begin
            if (!w_sel_valid || !w_stable)         w_state_next = ST_IDLE;
            else if (r_settle_cnt == LP_SETTLE_MAX) w_state_next = ST_CAPTURE;
            else                                    w_state_next = ST_SETTLE;
         end
         ST_CAPTURE: w_state_next = ST_HOLD;
         ST_HOLD: begin
            if (!w_sel_valid || (r_sel_s2 != r_sel_prev)) w_state_next = ST_IDLE;
            else                                          w_state_next = ST_HOLD;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register and settle counter. The counter runs only during an unbroken stable SETTLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_SETTLE) && w_sel_valid && w_stable && (r_settle_cnt != LP_SETTLE_MAX))
            r_settle_cnt <= r_settle_cnt + CNT_WIDTH'(1);
         else
            r_settle_cnt <= '0;
      end
   end

   // Capture the settled pattern and its decode into the selected digit slot
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_seg[i] <= 8'hFF;
            r_hex[i] <= 4'h0;
         end
         r_hex_ok <= 4'h0;
      end else if (w_capture) begin
         r_seg[w_sel_idx]    <= r_dec_s2;
         r_hex[w_sel_idx]    <= w_dec[3:0];
         r_hex_ok[w_sel_idx] <= w_dec[4];
      end
   end

   // Frame tracking. When all four digits are seen, pulse FRAME_DONE and restart the set.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seen       <= 4'h0;
         r_frame_done <= 1'b0;
      end else if (r_seen == 4'hF) begin
         r_seen       <= 4'h0;
         r_frame_done <= 1'b1;
      end else begin
         r_frame_done <= 1'b0;
         if (w_capture) r_seen[w_sel_idx] <= 1'b1;
      end
   end

`ifdef SEG_TIMEOUT_EN
   localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT      = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   logic [CNT_WIDTH-1:0] r_to_cnt;
   logic                 r_stale;

   // Frame watchdog. The counter saturates at the limit, and STALE holds until the next frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_to_cnt <= '0;
         r_stale  <= 1'b0;
      end else if (r_frame_done) begin
         r_to_cnt <= '0;
         r_stale  <= 1'b0;
      end else if (r_to_cnt != LP_TIMEOUT) begin
         r_to_cnt <= r_to_cnt + CNT_WIDTH'(1);
         if (r_to_cnt == LP_TIMEOUT_LAST) r_stale <= 1'b1;
      end
   end

   assign o_stale = r_stale;
`else
   assign o_stale = 1'b0;
`endif

   assign o_seg0       = r_seg[0];
   assign o_seg1       = r_seg[1];
   assign o_seg2       = r_seg[2];
   assign o_seg3       = r_seg[3];
   assign o_hex0       = r_hex[0];
   assign o_hex1       = r_hex[1];
   assign o_hex2       = r_hex[2];
   assign o_hex3       = r_hex[3];
   assign o_hex_ok     = r_hex_ok;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed testbench for seven_seg_capture. It uses scans, a glitch, invalid selects,
// a mid-dwell change, an undecodable glyph and reset in HOLD. It adds a timeout
// check when SEG_TIMEOUT_EN is defined.
module tb_seven_seg_capture;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] sel   = 4'hF;
   logic [7:0] dec   = 8'hFF;
   logic [7:0] seg0, seg1, seg2, seg3;
   logic [3:0] hex0, hex1, hex2, hex3, hex_ok;
   logic       frame_done, stale;

   int n_cmp = 0;
   int n_err = 0;
   int frame_cnt = 0;

   seven_seg_capture #(
      .SETTLE_CYCLES (8),
      .TIMEOUT_CYCLES(500),
      .CNT_WIDTH     (19)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_seg_select(sel),
      .i_dec_out   (dec),
      .o_seg0      (seg0),
      .o_seg1      (seg1),
      .o_seg2      (seg2),
      .o_seg3      (seg3),
      .o_hex0      (hex0),
      .o_hex1      (hex1),
      .o_hex2      (hex2),
      .o_hex3      (hex3),
      .o_hex_ok    (hex_ok),
      .o_frame_done(frame_done),
      .o_stale     (stale)
   );

   always #5 clk = ~clk;

   // Count FRAME_DONE cycles. A stuck-high pulse inflates the count.
   always @(posedge clk) if (frame_done === 1'b1) frame_cnt++;

   task automatic drive_digit(input int idx, input logic [7:0] pat, input int dwell);
      sel = ~(4'b0001 << idx);
      dec = pat;
      repeat (dwell) @(posedge clk);
      #1;
   endtask

   task automatic blank(input int cycles);
      sel = 4'hF;
      dec = 8'hFF;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_seg got %h exp FFFFFFFF", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin n_err++; $display("FAIL reset_hex got %h exp 0000", {hex3, hex2, hex1, hex0}); end
      n_cmp++; if (hex_ok !== 4'h0) begin n_err++; $display("FAIL reset_hex_ok got %h exp 0", hex_ok); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
      n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL reset_stale got %b exp 0", stale); end
      @(posedge clk); #1 rst_n = 1'b1;
      blank(5);
   endtask

   task automatic test_scan_basic;
      int f0;
      f0 = frame_cnt;
      drive_digit(0, 8'hC0, 1000);
      drive_digit(1, 8'hF9, 1000);
      drive_digit(2, 8'hA4, 1000);
      drive_digit(3, 8'hB0, 1000);
      blank(20);
      @(negedge clk);
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'hB0A4_F9C0) begin n_err++; $display("FAIL scan_seg got %h exp B0A4F9C0", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h3210) begin n_err++; $display("FAIL scan_hex got %h exp 3210", {hex3, hex2, hex1, hex0}); end
      n_cmp++; if (hex_ok !== 4'hF) begin n_err++; $display("FAIL scan_hex_ok got %h exp F", hex_ok); end
      n_cmp++; if ((frame_cnt - f0) !== 1) begin n_err++; $display("FAIL scan_frames got %0d exp 1", frame_cnt - f0); end
   endtask

   // Use letter glyphs. Revisit digit 0 mid-frame, which overwrites it without an extra frame.
   task automatic test_overwrite_glyphs;
      int f0;
      f0 = frame_cnt;
      drive_digit(0, 8'h8E, 60);
      drive_digit(1, 8'h86, 60);
      drive_digit(0, 8'hA1, 60);
      drive_digit(2, 8'hC6, 60);
      drive_digit(3, 8'h88, 60);
      blank(20);
      @(negedge clk);
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'h88C6_86A1) begin n_err++; $display("FAIL ovw_seg got %h exp 88C686A1", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'hACED) begin n_err++; $display("FAIL ovw_hex got %h exp ACED", {hex3, hex2, hex1, hex0}); end
      n_cmp++; if (hex_ok !== 4'hF) begin n_err++; $display("FAIL ovw_hex_ok got %h exp F", hex_ok); end
      n_cmp++; if ((frame_cnt - f0) !== 1) begin n_err++; $display("FAIL ovw_frames got %0d exp 1", frame_cnt - f0); end
   endtask

   task automatic test_glitch;
      int f0;
      f0 = frame_cnt;
      drive_digit(0, 8'h80, 5);
      blank(40);
      @(negedge clk);
      n_cmp++; if (seg0 !== 8'hA1) begin n_err++; $display("FAIL glitch_seg0 got %h exp A1", seg0); end
      n_cmp++; if ((frame_cnt - f0) !== 0) begin n_err++; $display("FAIL glitch_frames got %0d exp 0", frame_cnt - f0); end
   endtask

   task automatic test_invalid_select;
      int f0;
      f0 = frame_cnt;
      sel = 4'b1100; dec = 8'hC0;
      repeat (100) @(posedge clk);
      #1 sel = 4'b1111; dec = 8'hF9;
      repeat (100) @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'h88C6_86A1) begin n_err++; $display("FAIL invalid_seg got %h exp 88C686A1", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ((frame_cnt - f0) !== 0) begin n_err++; $display("FAIL invalid_frames got %0d exp 0", frame_cnt - f0); end
   endtask

   // Use an undecodable glyph on digit 1. Change digit 2 during its dwell; it must not recapture.
   task automatic test_mid_dwell_undecodable;
      int f0;
      f0 = frame_cnt;
      drive_digit(0, 8'hC0, 60);
      drive_digit(1, 8'h7F, 60);
      drive_digit(2, 8'h92, 20);
      dec = 8'h82;
      repeat (60) @(posedge clk);
      #1;
      drive_digit(3, 8'hB0, 60);
      blank(20);
      @(negedge clk);
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'hB092_7FC0) begin n_err++; $display("FAIL mid_seg got %h exp B0927FC0", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h3500) begin n_err++; $display("FAIL mid_hex got %h exp 3500", {hex3, hex2, hex1, hex0}); end
      n_cmp++; if (hex_ok !== 4'b1101) begin n_err++; $display("FAIL mid_hex_ok got %b exp 1101", hex_ok); end
      n_cmp++; if ((frame_cnt - f0) !== 1) begin n_err++; $display("FAIL mid_frames got %0d exp 1", frame_cnt - f0); end
   endtask

   // Reset while holding digit 2. The outputs clear at once, and the seen set clears too.
   task automatic test_reset_in_hold;
      int f0;
      drive_digit(0, 8'h88, 60);
      drive_digit(1, 8'h88, 60);
      drive_digit(2, 8'h88, 30);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rsthold_seg got %h exp FFFFFFFF", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ({hex_ok, hex3, hex2, hex1, hex0} !== 20'h0_0000) begin n_err++; $display("FAIL rsthold_hex got %h exp 00000", {hex_ok, hex3, hex2, hex1, hex0}); end
      sel = 4'hF; dec = 8'hFF;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      f0 = frame_cnt;
      drive_digit(3, 8'hB0, 60);
      blank(20);
      @(negedge clk);
      n_cmp++; if ({seg3, seg2, seg1, seg0} !== 32'hB0FF_FFFF) begin n_err++; $display("FAIL rsthold_after_seg got %h exp B0FFFFFF", {seg3, seg2, seg1, seg0}); end
      n_cmp++; if ((frame_cnt - f0) !== 0) begin n_err++; $display("FAIL rsthold_frames got %0d exp 0", frame_cnt - f0); end
   endtask

`ifdef SEG_TIMEOUT_EN
   task automatic test_timeout;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      blank(505);
      @(negedge clk);
      n_cmp++; if (stale !== 1'b1) begin n_err++; $display("FAIL timeout_stale_set got %b exp 1", stale); end
      drive_digit(0, 8'hC0, 60);
      drive_digit(1, 8'hF9, 60);
      drive_digit(2, 8'hA4, 60);
      drive_digit(3, 8'hB0, 60);
      blank(20);
      @(negedge clk);
      n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL timeout_stale_clear got %b exp 0", stale); end
   endtask
`endif

   initial begin
      test_reset();
      test_scan_basic();
      test_overwrite_glyphs();
      test_glitch();
      test_invalid_select();
      test_mid_dwell_undecodable();
      test_reset_in_hold();
`ifdef SEG_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
